cpu6502_memif: RTL
==================

# cpu6502_memif

CPU-side memory interface between the 6502 core's bus (address, write, data_o, data_i, ready) and an external req/ack memory port. The core never stalls on writes (its internal ready is forced high during write cycles), so writes are posted into a small write buffer. Reads stall the core via `cpu_ready` until the buffer has drained and the read has completed. The block thus provides ordered, wait-stated memory access for slow or shared memory.

## Interface
- `WBUF_DEPTH`, 4, write-buffer entries; must be a power of 2 and ≥ 4. The worst-case run of consecutive core write cycles is 3, during interrupt/BRK pushes.
- `clk` input 1: single clock, rising-edge.
- `reset` input 1: asynchronous, active-low (0 = reset).
- `cpu_address` input 16: core address for the current cycle.
- `cpu_write` input 1: core write strobe (current cycle is a write).
- `cpu_data_o` input 8: core write data.
- `cpu_data_i` output 8: read data to core.
- `cpu_ready` output 1: to core `ready`; 1 = current read completes this cycle.
- `mem_req` output 1: memory request.
- `mem_we` output 1: 1 = write request.
- `mem_addr` output 16: request address.
- `mem_wdata` output 8: write data.
- `mem_ack` input 1: transfer completes this cycle; ignored when `mem_req` = 0.
- `mem_rdata` input 8: read data, valid with `mem_ack` on reads.
- `wbuf_overflow` output 1: sticky error flag; a write was dropped on a full buffer.

## Operation
- Write buffer: FIFO of {addr[15:0], data[7:0]}.
  - Push every cycle `cpu_write` = 1.
  - Pop when a WR transfer is acked.
  - Push and pop in the same cycle is allowed at any occupancy, including full; the count is unchanged.
  - Push when full without a simultaneous pop drops the write and sets `wbuf_overflow` until reset.
- FSM states: IDLE, WR, RD.
  - IDLE → WR when the buffer is non-empty. This includes a write pushed this cycle, which is visible next cycle.
  - IDLE → RD when the buffer is empty and `cpu_write` = 0.
  - WR: present the buffer head. On `mem_ack`, pop. If the buffer will still be non-empty after the pop and push, stay in WR (back-to-back transfer); else → IDLE.
  - RD: present `cpu_address` with `mem_we` = 0. On `mem_ack` → IDLE.
- Ordering: reads are never issued while the buffer is non-empty. There is no forwarding, so a read always observes all earlier writes.
- `mem_req` = (state == WR || state == RD). `mem_we` = (state == WR).
- `mem_addr`/`mem_wdata` come from the buffer head in WR and from `cpu_address` in RD. `mem_wdata` = 0 when not in WR.
- `cpu_ready`:
  - 1 when `cpu_write` = 1.
  - 1 when state == RD and `mem_ack` = 1; combinational.
  - 0 otherwise.
- `cpu_data_i` = `mem_rdata` when state == RD and `mem_ack` = 1. Otherwise it holds the last read value (registered copy).
- Memory-side handshake: `mem_addr`/`mem_we`/`mem_wdata` are stable while `mem_req` = 1 and no ack has occurred.

## Timing
- Reset (async assert, synchronous-safe deassert):
  - state = IDLE, buffer empty.
  - `mem_req` = 0, `mem_we` = 0, `mem_addr` = 0, `mem_wdata` = 0.
  - `cpu_ready` = 0 unless `cpu_write` = 1.
  - `cpu_data_i` = 0, `wbuf_overflow` = 0.
- Read latency, empty buffer, zero-wait memory (ack in the first req cycle): the core read stalls 1 cycle. Cycle 0 is IDLE with `cpu_ready` = 0; cycle 1 is RD with ack and `cpu_ready` = 1.
- Each memory wait state adds 1 stall cycle.
- Read behind N buffered writes, zero-wait memory: stall N+1 cycles.
- Write throughput with zero-wait memory: 1 transfer per cycle. Write-to-`mem_req` latency: 1 cycle.
- Reset mid-transfer: the request is abandoned immediately (`mem_req` drops asynchronously). The memory side must tolerate the abort, and buffered writes are discarded.
- `mem_ack` in IDLE is ignored, with no state change.

## Structure
- Shared include `memif_inc.vh`:
  - FSM state encodings: IDLE = 2'd0, WR = 2'd1, RD = 2'd2.
  - Buffer entry field offsets.
- Sub-module `memif_wbuf`: parameterised synchronous FIFO with push, pop, head, empty, full and an overflow pulse; async active-low reset.
- Top level contains the FSM, output muxes and the `cpu_data_i` hold register.

## Test plan
- Reset, then a read of 0x1234 with `mem_ack` tied 1 and `mem_rdata` = 0xA5: `mem_req` rises the cycle after the read appears; `cpu_ready` = 1 with `cpu_data_i` = 0xA5 in that same cycle; the next cycle is IDLE.
- Three consecutive writes (0x01FF←0x12, 0x01FE←0x34, 0x01FD←0x56), then a read of 0x01FD, with 2-wait-state memory: the writes reach memory in order; the read is issued only after the third ack; no overflow occurs.
- Push with a simultaneous pop while the buffer is full (4 entries, ack on the head): occupancy stays 4, no data is lost, and `wbuf_overflow` stays 0.
- Fifth write into a full buffer with `mem_ack` = 0: the write is dropped, `wbuf_overflow` = 1 and remains set until reset.
- Assert `reset` = 0 mid-RD with `mem_ack` withheld: `mem_req` drops immediately, all outputs reach their reset values, and after release a fresh read completes normally.
- Spurious `mem_ack` = 1 in IDLE with the buffer empty and a write on the CPU side: there is no pop and no state change; the write is pushed and transferred next cycle.

Source files
------------

// File: rtl/cpu6502_memif_pkg.sv
// Shared types for the 6502 memory interface: FSM state encoding and
// the write-buffer entry layout.
package cpu6502_memif_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WR   = 2'd1,
      ST_RD   = 2'd2
   } state_e;

   // Address in the upper bits, data in the low byte.
   typedef struct packed {
      logic [15:0] addr;
      logic [7:0]  data;
   } wbuf_entry_t;

   localparam int unsigned ENTRY_W = $bits(wbuf_entry_t);

endpackage

// File: rtl/memif_wbuf.sv
// Synchronous FIFO used as the posted-write buffer. A push on a full buffer
// is accepted only when a pop frees a slot in the same cycle.
module memif_wbuf #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 24
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       push_i,
   input  logic                       pop_i,
   input  logic [WIDTH-1:0]           wdata_i,
   output logic [WIDTH-1:0]           head_o,
   output logic                       empty_o,
   output logic [$clog2(DEPTH):0]     count_o,
   output logic                       overflow_o
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      count_q, count_d;
   logic             full;
   logic             do_push;
   logic             do_pop;

   assign full       = (count_q == (AW+1)'(DEPTH));
   assign empty_o    = (count_q == '0);
   assign count_o    = count_q;
   assign head_o     = mem_q[rd_ptr_q];
   assign do_pop     = pop_i && !empty_o;
   assign do_push    = push_i && (!full || do_pop);
   assign overflow_o = push_i && full && !do_pop;

   // NOTE: every variable driven here gets a default first, so no path can infer a latch.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // NOTE: storage is not reset; entries are only visible once the pointers say they are valid.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= wdata_i;
   end

endmodule

// File: rtl/cpu6502_memif.sv
// Bridges the 6502 core bus to a req/ack memory port: writes are posted into
// a small FIFO, reads stall the core until the FIFO drains and the read acks.
module cpu6502_memif
   import cpu6502_memif_pkg::*;
#(
   parameter int WBUF_DEPTH = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] cpu_address,
   input  logic        cpu_write,
   input  logic [7:0]  cpu_data_o,
   output logic [7:0]  cpu_data_i,
   output logic        cpu_ready,
   output logic        mem_req,
   output logic        mem_we,
   output logic [15:0] mem_addr,
   output logic [7:0]  mem_wdata,
   input  logic        mem_ack,
   input  logic [7:0]  mem_rdata,
   output logic        wbuf_overflow
);

   localparam int CNT_W = $clog2(WBUF_DEPTH) + 1;

   if (WBUF_DEPTH < 4 || (WBUF_DEPTH & (WBUF_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("WBUF_DEPTH must be a power of 2 and at least 4");
   end

   state_e          state_q, state_d;
   wbuf_entry_t     push_entry;
   wbuf_entry_t     head;
   logic            wbuf_empty;
   logic            wbuf_pop;
   logic            wbuf_ovf_pulse;
   logic [CNT_W-1:0] wbuf_count;
   logic            last_entry;
   logic            rd_ack;
   logic [7:0]      rdata_q;
   logic            overflow_q;

   assign push_entry = '{addr: cpu_address, data: cpu_data_o};
   assign wbuf_pop   = (state_q == ST_WR) && mem_ack;
   assign rd_ack     = (state_q == ST_RD) && mem_ack;
   assign last_entry = (wbuf_count == CNT_W'(1));

   memif_wbuf #(
      .DEPTH (WBUF_DEPTH),
      .WIDTH (ENTRY_W)
   ) u_wbuf (
      .clk        (clk),
      .reset      (reset),
      .push_i     (cpu_write),
      .pop_i      (wbuf_pop),
      .wdata_i    (push_entry),
      .head_o     (head),
      .empty_o    (wbuf_empty),
      .count_o    (wbuf_count),
      .overflow_o (wbuf_ovf_pulse)
   );

   always_comb begin
      state_d   = state_q;
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      case (state_q)
         ST_IDLE: begin
            // A write pushed this cycle counts as pending, keeping reads ordered behind it.
            if (!wbuf_empty || cpu_write) state_d = ST_WR;
            else                          state_d = ST_RD;
         end
         ST_WR: begin
            mem_req   = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = head.addr;
            mem_wdata = head.data;
            if (mem_ack && last_entry && !cpu_write) state_d = ST_IDLE;
         end
         ST_RD: begin
            mem_req  = 1'b1;
            mem_addr = cpu_address;
            if (mem_ack) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign cpu_ready     = cpu_write || rd_ack;
   assign cpu_data_i    = rd_ack ? mem_rdata : rdata_q;
   assign wbuf_overflow = overflow_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= ST_IDLE;
         rdata_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         state_q <= state_d;
         if (rd_ack)         rdata_q    <= mem_rdata;
         if (wbuf_ovf_pulse) overflow_q <= 1'b1;
      end
   end

endmodule
